// File: rtl/uart_pkg.sv
// +-----------------------------------------------------------------------+
// | uart_pkg : shared state encoding and line levels for the FIFO UART tx. |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int   CLKS_PER_BIT_DEFAULT = 16;
  localparam logic IDLE_LEVEL           = 1'b1;
  localparam logic START_LEVEL          = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// +-----------------------------------------------------------------------+
// | baud_tick_gen : bit-period counter, one-cycle tick every CLKS_PER_BIT. |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // pre_tick lets the parent register an output that must line up with the tick cycle
  assign bit_tick = (r_cnt == C_LAST);
  assign pre_tick = (r_cnt == C_PRE);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// +-----------------------------------------------------------------------+
// | fifo_uart_tx : pops bytes from a sync FIFO and sends them as UART      |
// | frames, LSB first. UART_TX_PARITY_EN adds an even parity bit (8E1).    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_W - 1);

  uart_tx_state_t    r_state;
  uart_tx_state_t    w_next_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic              w_bit_tick;
  logic              w_pre_tick;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_state == LOAD),
    .bit_tick (w_bit_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (enable && !fifo_empty) w_next_state = REQ;
      REQ:   w_next_state = LOAD;
      LOAD:  w_next_state = START;
      START: if (w_bit_tick) w_next_state = DATA;
      DATA: begin
        if (w_bit_tick && (r_bit_idx == C_LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_tick) w_next_state = STOP;
`endif
      STOP:    if (w_bit_tick) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= IDLE_LEVEL;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_rd_en <= (w_next_state == REQ);
      r_busy  <= (w_next_state != IDLE);
      r_done  <= (r_state == STOP) && w_pre_tick;
      case (r_state)
        LOAD: begin
          r_shift   <= fifo_data;
          r_bit_idx <= '0;
          r_tx      <= START_LEVEL;
`ifdef UART_TX_PARITY_EN
          r_parity  <= ^fifo_data;
`endif
        end
        START: if (w_bit_tick) r_tx <= r_shift[0];
        DATA: begin
          if (w_bit_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == C_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              r_tx <= r_parity;
`else
              r_tx <= IDLE_LEVEL;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (w_bit_tick) r_tx <= IDLE_LEVEL;
`endif
        default: r_tx <= r_tx;
      endcase
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// +-----------------------------------------------------------------------+
// | tb_fifo_uart_tx : directed + random frames against a bit-list model.   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  // FIFO model: pointers owned by separate processes, storage written only by the stimulus
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [DW-1:0] exp_q[$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr & 255];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr & 255] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  task automatic wait_rd(output int waited);
    waited = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        waited = n;
        break;
      end
    end
  endtask

  // Expected line = start bit, payload LSB first, optional even parity, stop bit; each held C cycles
  task automatic run_frame(input int drop_en_at);
    int waited;
    logic [DW-1:0] b;
    bit fr[$];
    wait_rd(waited);
    chk("rd_en_latency", waited, 1);
    if (waited == 0) return;
    b = exp_q.pop_front();
    chk("req_tx_high", tx, 1);
    @(negedge clk);
    chk("load_tx_high", tx, 1);
    chk("load_busy", busy, 1);
    fr.push_back(1'b0);
    for (int i = 0; i < DW; i++) fr.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    fr.push_back(^b);
`endif
    fr.push_back(1'b1);
    for (int i = 0; i < fr.size() * C; i++) begin
      @(negedge clk);
      if (i == drop_en_at) enable = 1'b0;
      chk("tx_bit", tx, fr[i / C]);
      chk("busy_frame", busy, 1);
      chk("done_frame", done, (i == fr.size() * C - 1) ? 1 : 0);
      chk("rd_en_frame", fifo_rd_en, 0);
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_tx", tx, 1);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int r0, d0;
    logic [DW-1:0] z;

    // Reset held with data waiting
    enable = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    reset = 1'b1;

    // Single byte A5
    r0 = rd_cnt; d0 = done_cnt;
    run_frame(-1);
    chk("single_rd_pulses", rd_cnt - r0, 1);
    chk("single_done_pulses", done_cnt - d0, 1);

    // Back-to-back 00 then FF
    r0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    run_frame(-1);
    run_frame(-1);
    chk("b2b_rd_pulses", rd_cnt - r0, 2);

    // Empty FIFO with enable
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("empty_rd_en", fifo_rd_en, 0);
      chk("empty_tx", tx, 1);
    end
    // Data present but disabled
    enable = 1'b0;
    push(DW'($urandom));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("dis_rd_en", fifo_rd_en, 0);
      chk("dis_tx", tx, 1);
    end

    // Enable dropped mid-frame: frame completes, remaining byte stays queued
    push(DW'($urandom));
    r0 = rd_cnt;
    enable = 1'b1;
    run_frame(20);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("drop_rd_en", fifo_rd_en, 0);
      chk("drop_tx", tx, 1);
    end
    chk("drop_rd_pulses", rd_cnt - r0, 1);
    enable = 1'b1;
    run_frame(-1);

    // Reset during data bit 3; popped byte is abandoned
    z = DW'($urandom) & 8'hF7;
    push(z);
    push(DW'($urandom));
    begin
      int waited;
      wait_rd(waited);
      chk("mid_rd_en_latency", waited, 1);
      void'(exp_q.pop_front());
      repeat (4 * C + 3) @(negedge clk);
      chk("mid_pre_tx", tx, 0);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd_en", fifo_rd_en, 0);
      @(negedge clk);
      reset = 1'b1;
    end
    run_frame(-1);

    // Random back-to-back frames
    r0 = rd_cnt; d0 = done_cnt;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    for (int i = 0; i < 5; i++) run_frame(-1);
    chk("rand_rd_pulses", rd_cnt - r0, 5);
    chk("rand_done_pulses", done_cnt - d0, 5);

    // Parity corner bytes
    push(8'hA5);
    push(8'h07);
    run_frame(-1);
    run_frame(-1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
